pwm_capture: RTL

//  Measures an incoming PWM waveform; the decode side of the team's PWM generator.
//  - Reports high time and period in clk cycles (e.g. servo or RC inputs, motor-driver feedback on the rover).
//  - Input is asynchronous to clk and is synchronised internally.
//  - Each completed period (rising edge to rising edge) produces one measurement, flagged by a 1-cycle strobe.
//  - Loss of signal, or a stuck 0%/100% level, is flagged by a timeout.

---
 rtl/pwm_capture.sv | 117 +++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an asynchronous
// PWM input in clk cycles, flagging loss of signal or stuck levels by timeout.
module pwm_capture #(
  parameter int CLK_FREQ    = 100000000,
  parameter int PWM_FREQ    = 20000,
  parameter int TIMEOUT_CNT = 4 * (CLK_FREQ / PWM_FREQ),
  parameter int CNT_WL      = $clog2(TIMEOUT_CNT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pwm,
  output logic [CNT_WL-1:0] o_high_cnt,
  output logic [CNT_WL-1:0] o_period_cnt,
  output logic              o_valid,
  output logic              o_timeout,
  output logic              o_level
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_WL-1:0] TMAX = CNT_WL'(TIMEOUT_CNT);
  localparam logic [CNT_WL-1:0] ONE  = CNT_WL'(1);

  state_t            state;
  logic              s1;
  logic              s2;
  logic              s3;
  logic [CNT_WL-1:0] per_cnt;
  logic [CNT_WL-1:0] hi_cnt;
  logic [CNT_WL-1:0] hi_lat;
  logic              rise;
  logic              fall;
  logic              at_max;
  logic [CNT_WL-1:0] per_inc;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign at_max  = (per_cnt == TMAX);
  // a fall on the limit cycle still counts, so hold the count at the limit
  assign per_inc = at_max ? TMAX : per_cnt + ONE;
  assign o_level = s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= IDLE;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      hi_lat       <= '0;
      o_high_cnt   <= '0;
      o_period_cnt <= '0;
      o_valid      <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      s1      <= i_pwm;
      s2      <= s1;
      s3      <= s2;
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state   <= HIGH;
            per_cnt <= ONE;
            hi_cnt  <= ONE;
          end else if (at_max) begin
            o_timeout <= 1'b1;
            per_cnt   <= '0;
          end else begin
            per_cnt <= per_cnt + ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            state   <= LOW;
            hi_lat  <= hi_cnt;
            per_cnt <= per_inc;
          end else if (at_max) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
            per_cnt   <= '0;
          end else begin
            per_cnt <= per_cnt + ONE;
            hi_cnt  <= hi_cnt + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            o_period_cnt <= per_cnt;
            o_high_cnt   <= hi_lat;
            o_valid      <= 1'b1;
            o_timeout    <= 1'b0;
            state        <= HIGH;
            per_cnt      <= ONE;
            hi_cnt       <= ONE;
          end else if (at_max) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
            per_cnt   <= '0;
          end else begin
            per_cnt <= per_cnt + ONE;
          end
        end
        default: begin
          state   <= IDLE;
          per_cnt <= '0;
        end
      endcase
    end
  end

endmodule
